ifid_skid_reg: RTL and testbench
================================

# ifid_skid_reg

Two-entry skid-buffered pipeline register between the fetch stage and the decode stage of the MIPS pipeline, carrying PC and instruction with a valid/ready handshake. Decouples fetch from decode stalls without a combinational ready path back into fetch, and supports a synchronous flush for branch/jump redirects. Its storage is plain enable-gated flops with asynchronous reset; all control is registered.

## Interface
- PC_W, 32, width of program-counter field
- INSTR_W, 32, width of instruction field
- clk  in  1  rising-edge clock
- arst_n  in  1  asynchronous, active-low reset; one clock domain only
- flush  in  1  synchronous redirect flush, highest priority
- in_valid  in  1  fetch presents a word
- in_ready  out  1  this block can accept (registered)
- in_pc  in  PC_W  fetched PC
- in_instr  in  INSTR_W  fetched instruction
- out_valid  out  1  decode-side word valid (registered)
- out_ready  in  1  decode accepts
- out_pc  out  PC_W  PC to decode
- out_instr  out  INSTR_W  instruction to decode

## Operation
- Storage: main entry (drives out_*) and skid entry. State: EMPTY, ONE (main valid), FULL (main + skid valid).
- Input fire = in_valid & in_ready; output fire = out_valid & out_ready.
- in_ready = registered (next_state != FULL); in_ready is 0 in FULL.
- EMPTY: input fire -> main <= in, go ONE.
- ONE: in+out fire -> main <= in, stay ONE; out only -> EMPTY; in only -> skid <= in, go FULL; neither -> hold.
- FULL: out fire -> main <= skid, go ONE; no input accepted; otherwise hold.
- flush = 1: state -> EMPTY next edge, overriding every transition; a word offered in the same cycle is dropped even if in_valid & in_ready; skid discarded.
- Whenever main is invalid (EMPTY, after flush, after drain), out_pc = 0 and out_instr = NOP (32'h0000_0000, sll $0,$0,0) so decode sees a bubble even if out_valid is ignored.
- Order preserved strictly; no word duplicated or lost except by flush.

## Timing
- Reset (arst_n = 0, immediate, no clock needed): state EMPTY, out_valid 0, out_pc 0, out_instr NOP, in_ready 0, skid cleared.
- First rising edge after arst_n deasserts: in_ready -> 1.
- Latency in -> out: 1 cycle (accepted at edge N, out_valid at N).
- Throughput: 1 word/cycle while out_ready = 1.
- Decode stall: at most one extra word accepted after out_ready falls (skid), then in_ready = 0 from the next cycle.
- Release from FULL: out fire moves skid to main; in_ready = 1 the following cycle.
- Reset mid-operation: all contents lost, outputs go to reset values asynchronously.
- flush with out_ready = 1: word currently in main counts as consumed by decode that cycle; next cycle out_valid = 0.

## Structure
- Package ifid_pkg: NOP_INSTR constant (32'h0000_0000), state encoding (EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b10), default PC_W/INSTR_W.
- One sub-module: ifid_entry_reg -- PC+instruction register with load enable, synchronous clear-to-NOP, asynchronous active-low reset; instantiated twice (main, skid).
- Control FSM and in_ready/out_valid registers live in the top.

## Test plan
- Reset: hold arst_n = 0 mid-stream -> out_valid 0, out_instr 32'h0, in_ready 0 immediately; first edge after release -> in_ready 1.
- Streaming: PCs 0x400000, 0x400004, 0x400008 back-to-back, out_ready = 1 -> each appears one cycle later, 3 consecutive out fires, in_ready never drops.
- Stall: out_ready = 0 after first word (0x400000) -> 0x400004 lands in skid, in_ready 0 next cycle; out_ready = 1 -> 0x400000 then 0x400004 in order, in_ready 1 again.
- Flush in FULL: main 0x400010, skid 0x400014, flush = 1 with in_valid of 0x400018 -> next cycle out_valid 0, out_instr NOP, 0x400018 not delivered; next offered 0x400100 delivered first.
- Random in_valid/out_ready (10k cycles, scoreboard) -> exact in-order match, no combinational path from out_ready to in_ready.

Source files
------------

// File: rtl/ifid_pkg.sv
// Shared definitions for the IF/ID skid-buffered pipeline register.
package ifid_pkg;

  // Default field widths for a 32-bit MIPS datapath
  localparam int DEF_PC_W    = 32;
  localparam int DEF_INSTR_W = 32;

  // sll $0,$0,0 -- the canonical MIPS bubble
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Occupancy of the two-entry buffer
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } ifid_state_t;

endpackage

// File: rtl/ifid_entry_reg.sv
// One PC + instruction storage entry: load-enabled, clearable to a bubble.
module ifid_entry_reg
  import ifid_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               load,
  input  logic               clear,
  input  logic [PC_W-1:0]    d_pc,
  input  logic [INSTR_W-1:0] d_instr,
  output logic [PC_W-1:0]    q_pc,
  output logic [INSTR_W-1:0] q_instr
);

  // Clear wins over load so a flushed or drained entry always reads as a NOP bubble
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      q_pc    <= '0;
      q_instr <= INSTR_W'(NOP_INSTR);
    end else if (clear) begin
      q_pc    <= '0;
      q_instr <= INSTR_W'(NOP_INSTR);
    end else if (load) begin
      q_pc    <= d_pc;
      q_instr <= d_instr;
    end
  end

endmodule

// File: rtl/ifid_skid_reg.sv
// Two-entry skid buffer between fetch and decode; in_ready and out_valid are
// registered so decode stalls never reach fetch through combinational logic.
module ifid_skid_reg
  import ifid_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr
);

  ifid_state_t        state;
  ifid_state_t        next_state;
  logic               in_fire;
  logic               out_fire;
  logic               main_load;
  logic               main_clear;
  logic               skid_load;
  logic               skid_clear;
  logic [PC_W-1:0]    main_d_pc;
  logic [INSTR_W-1:0] main_d_instr;
  logic [PC_W-1:0]    skid_pc;
  logic [INSTR_W-1:0] skid_instr;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Occupancy transitions; flush empties the buffer regardless of handshakes
  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (in_fire) next_state = ONE;
        ONE: begin
          if (in_fire && !out_fire)      next_state = FULL;
          else if (!in_fire && out_fire) next_state = EMPTY;
        end
        FULL:    if (out_fire) next_state = ONE;
        default: next_state = EMPTY;
      endcase
    end
  end

  // Entry enables: main refills from skid when draining FULL, otherwise from fetch
  always_comb begin
    main_load    = 1'b0;
    main_clear   = 1'b0;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
    main_d_pc    = in_pc;
    main_d_instr = in_instr;
    if (state == FULL) begin
      main_d_pc    = skid_pc;
      main_d_instr = skid_instr;
    end
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        EMPTY:   main_load = in_fire;
        ONE: begin
          main_load  = in_fire & out_fire;
          skid_load  = in_fire & ~out_fire;
          main_clear = out_fire & ~in_fire;
        end
        FULL: begin
          main_load  = out_fire;
          skid_clear = out_fire;
        end
        default: begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  // Registered state and handshake outputs derived from the next occupancy
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= next_state;
      in_ready  <= (next_state != FULL);
      out_valid <= (next_state != EMPTY);
    end
  end

  ifid_entry_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_main (
    .clk     (clk),
    .arst_n  (arst_n),
    .load    (main_load),
    .clear   (main_clear),
    .d_pc    (main_d_pc),
    .d_instr (main_d_instr),
    .q_pc    (out_pc),
    .q_instr (out_instr)
  );

  ifid_entry_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_skid (
    .clk     (clk),
    .arst_n  (arst_n),
    .load    (skid_load),
    .clear   (skid_clear),
    .d_pc    (in_pc),
    .d_instr (in_instr),
    .q_pc    (skid_pc),
    .q_instr (skid_instr)
  );

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Directed and scoreboard checks for the IF/ID skid-buffered pipeline register.
module tb_ifid_skid_reg;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int checks = 0;
  int passes = 0;

  ifid_skid_reg #(.PC_W(32), .INSTR_W(32)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;
    #2 arst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); else passes++;
    checks++; if (out_pc !== 32'h0) $display("[TB] FAIL reset_out_pc: got %h expected 00000000", out_pc); else passes++;
    checks++; if (out_instr !== 32'h0) $display("[TB] FAIL reset_out_instr: got %h expected 00000000", out_instr); else passes++;
    step(); step();
    checks++; if (in_ready !== 1'b0) $display("[TB] FAIL reset_held_in_ready: got %b expected 0", in_ready); else passes++;
    arst_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_release_in_ready: got %b expected 1", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_release_out_valid: got %b expected 0", out_valid); else passes++;
  endtask

  task automatic test_streaming();
    logic [31:0] pcs [3];
    logic [31:0] ins [3];
    pcs[0] = 32'h0040_0000; ins[0] = 32'h3c01_0040;
    pcs[1] = 32'h0040_0004; ins[1] = 32'h2421_0004;
    pcs[2] = 32'h0040_0008; ins[2] = 32'h8c22_0000;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_pc = pcs[i]; in_instr = ins[i];
      step();
      checks++; if (out_valid !== 1'b1) $display("[TB] FAIL stream_valid_%0d: got %b expected 1", i, out_valid); else passes++;
      checks++; if (out_pc !== pcs[i]) $display("[TB] FAIL stream_pc_%0d: got %h expected %h", i, out_pc, pcs[i]); else passes++;
      checks++; if (out_instr !== ins[i]) $display("[TB] FAIL stream_instr_%0d: got %h expected %h", i, out_instr, ins[i]); else passes++;
      checks++; if (in_ready !== 1'b1) $display("[TB] FAIL stream_in_ready_%0d: got %b expected 1", i, in_ready); else passes++;
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL stream_drain_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (out_instr !== 32'h0) $display("[TB] FAIL stream_drain_instr: got %h expected 00000000", out_instr); else passes++;
    checks++; if (out_pc !== 32'h0) $display("[TB] FAIL stream_drain_pc: got %h expected 00000000", out_pc); else passes++;
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_valid  = 1'b1; in_pc = 32'h0040_0000; in_instr = 32'h1111_0000;
    step();
    checks++; if (out_pc !== 32'h0040_0000) $display("[TB] FAIL stall_first_pc: got %h expected 00400000", out_pc); else passes++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL stall_one_in_ready: got %b expected 1", in_ready); else passes++;
    in_pc = 32'h0040_0004; in_instr = 32'h1111_0004;
    step();
    checks++; if (in_ready !== 1'b0) $display("[TB] FAIL stall_full_in_ready: got %b expected 0", in_ready); else passes++;
    checks++; if (out_pc !== 32'h0040_0000) $display("[TB] FAIL stall_full_pc: got %h expected 00400000", out_pc); else passes++;
    in_pc = 32'h0040_0008; in_instr = 32'h1111_0008;
    step();
    checks++; if (in_ready !== 1'b0) $display("[TB] FAIL stall_hold_in_ready: got %b expected 0", in_ready); else passes++;
    checks++; if (out_instr !== 32'h1111_0000) $display("[TB] FAIL stall_hold_instr: got %h expected 11110000", out_instr); else passes++;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) $display("[TB] FAIL stall_no_comb_path: got %b expected 0", in_ready); else passes++;
    step();
    checks++; if (out_pc !== 32'h0040_0004) $display("[TB] FAIL stall_release_pc: got %h expected 00400004", out_pc); else passes++;
    checks++; if (out_instr !== 32'h1111_0004) $display("[TB] FAIL stall_release_instr: got %h expected 11110004", out_instr); else passes++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL stall_release_in_ready: got %b expected 1", in_ready); else passes++;
    step();
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL stall_empty_valid: got %b expected 0", out_valid); else passes++;
  endtask

  task automatic test_flush_full();
    out_ready = 1'b0;
    in_valid  = 1'b1; in_pc = 32'h0040_0010; in_instr = 32'h2222_0010;
    step();
    in_pc = 32'h0040_0014; in_instr = 32'h2222_0014;
    step();
    checks++; if (in_ready !== 1'b0) $display("[TB] FAIL flush_pre_in_ready: got %b expected 0", in_ready); else passes++;
    checks++; if (out_pc !== 32'h0040_0010) $display("[TB] FAIL flush_pre_pc: got %h expected 00400010", out_pc); else passes++;
    flush = 1'b1; in_pc = 32'h0040_0018; in_instr = 32'h2222_0018;
    step();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL flush_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (out_instr !== 32'h0) $display("[TB] FAIL flush_instr: got %h expected 00000000", out_instr); else passes++;
    checks++; if (out_pc !== 32'h0) $display("[TB] FAIL flush_pc: got %h expected 00000000", out_pc); else passes++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL flush_in_ready: got %b expected 1", in_ready); else passes++;
    in_pc = 32'h0040_0100; in_instr = 32'h2222_0100; out_ready = 1'b1;
    step();
    checks++; if (out_pc !== 32'h0040_0100) $display("[TB] FAIL flush_next_pc: got %h expected 00400100", out_pc); else passes++;
    checks++; if (out_instr !== 32'h2222_0100) $display("[TB] FAIL flush_next_instr: got %h expected 22220100", out_instr); else passes++;
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL flush_after_valid: got %b expected 0", out_valid); else passes++;
  endtask

  task automatic test_flush_one();
    out_ready = 1'b0;
    in_valid  = 1'b1; in_pc = 32'h0040_0020; in_instr = 32'h3333_0020;
    step();
    flush = 1'b1; in_pc = 32'h0040_0024; in_instr = 32'h3333_0024;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL flush_one_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL flush_one_in_ready: got %b expected 1", in_ready); else passes++;
    step();
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL flush_one_dropped: got %b expected 0", out_valid); else passes++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1; in_pc = 32'h0040_0030; in_instr = 32'h4444_0030;
    step();
    in_pc = 32'h0040_0034; in_instr = 32'h4444_0034;
    step();
    in_valid = 1'b0;
    #2 arst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_reset_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (out_instr !== 32'h0) $display("[TB] FAIL mid_reset_instr: got %h expected 00000000", out_instr); else passes++;
    checks++; if (in_ready !== 1'b0) $display("[TB] FAIL mid_reset_in_ready: got %b expected 0", in_ready); else passes++;
    step();
    arst_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL mid_reset_release: got %b expected 1", in_ready); else passes++;
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_reset_skid_lost: got %b expected 0", out_valid); else passes++;
  endtask

  task automatic test_random();
    logic [63:0] q [$];
    logic [31:0] next_pc;
    logic        ir;
    logic        ov;
    next_pc = 32'h0050_0000;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 63) == 0);
      in_pc     = next_pc;
      in_instr  = ~next_pc ^ 32'h5a5a_0000;
      #1;
      ir = in_ready;
      ov = out_valid;
      if (ov && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          $display("[TB] FAIL rand_unexpected_word cyc %0d: got %h expected none", cyc, out_pc);
        end else begin
          if ({out_pc, out_instr} !== q[0])
            $display("[TB] FAIL rand_order cyc %0d: got %h expected %h", cyc, {out_pc, out_instr}, q[0]);
          else
            passes++;
          void'(q.pop_front());
        end
      end
      if (in_valid && ir) next_pc = next_pc + 32'd4;
      if (flush) q.delete();
      else if (in_valid && ir) q.push_back({in_pc, in_instr});
      step();
      checks++; if (out_valid !== (q.size() != 0)) $display("[TB] FAIL rand_out_valid cyc %0d: got %b expected %b", cyc, out_valid, q.size() != 0); else passes++;
      checks++; if (in_ready !== (q.size() != 2)) $display("[TB] FAIL rand_in_ready cyc %0d: got %b expected %b", cyc, in_ready, q.size() != 2); else passes++;
      if (q.size() == 0) begin
        checks++; if ({out_pc, out_instr} !== 64'h0) $display("[TB] FAIL rand_bubble cyc %0d: got %h expected 0", cyc, {out_pc, out_instr}); else passes++;
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_flush_full();
    test_flush_one();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
